// File: rtl/ps2_pkg.sv
// Shared constants, decoder state encoding and key event layout for the
// PS/2 keyboard receive path.
package ps2_pkg;

  localparam logic [7:0] SCAN_E0  = 8'hE0;
  localparam logic [7:0] SCAN_F0  = 8'hF0;
  localparam logic [7:0] SCAN_BAT = 8'hAA;
  localparam int         FRAME_BITS = 11;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_E0,
    DEC_F0,
    DEC_E0F0
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_evt_t;

  localparam int EVT_W = $bits(key_evt_t);

  // Odd parity over data plus parity bit holds when the XOR is 1.
  function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
    return ^data_and_parity;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous FIFO of key events; the head entry is presented directly from
// storage so it stays stable until popped.
module key_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [EVT_W-1:0]         din,
  output logic [EVT_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [EVT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver: synchronizes the raw lines, frames 11-bit packets,
// folds E0/F0 prefixes into key events and queues them for the host.
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_release,
  output logic                          evt_extended,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          reset_seen,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_cur;
  logic                   data_s;
  logic                   fall;

  logic [3:0]             bit_cnt;
  logic [FRAME_BITS-2:0]  shreg;
  logic [TW-1:0]          tmr;
  logic [FRAME_BITS-1:0]  word;
  logic                   last_bit;
  logic                   timeout;
  logic                   start_ok;
  logic                   stop_ok;
  logic                   par_ok;
  logic                   byte_valid;
  logic [7:0]             rx_byte;

  dec_state_t             state;
  dec_state_t             next_state;
  logic                   push;
  logic                   bat;
  key_evt_t               new_evt;
  key_evt_t               head;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Synchronizers idle high so reset never looks like a clock fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_cur;
    end
  end

  assign clk_cur = clk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign fall    = clk_prev && !clk_cur;

  always_comb begin
    word     = {data_s, shreg};
    start_ok = !word[0];
    stop_ok  = word[FRAME_BITS-1];
    par_ok   = odd_parity_ok(word[9:1]);
    last_bit = fall && (bit_cnt == 4'(FRAME_BITS - 1));
    timeout  = !fall && (bit_cnt != '0) && (tmr == TW'(TIMEOUT_CYCLES - 1));
  end

  // The frame is judged on the fall that delivers the stop bit, so the
  // error pulses and the decoded byte appear exactly one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      tmr        <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (fall) begin
        shreg <= {data_s, shreg[FRAME_BITS-2:1]};
        tmr   <= '0;
        if (last_bit) begin
          bit_cnt <= '0;
          rx_byte <= word[8:1];
          if (!start_ok || !stop_ok) frame_err  <= 1'b1;
          else if (!par_ok)          parity_err <= 1'b1;
          else                       byte_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt != '0) begin
        if (timeout) begin
          bit_cnt   <= '0;
          tmr       <= '0;
          frame_err <= 1'b1;
        end else begin
          tmr <= tmr + 1'b1;
        end
      end else begin
        tmr <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= DEC_IDLE;
      reset_seen <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= next_state;
      reset_seen <= bat;
      overflow   <= push && fifo_full && !pop;
    end
  end

  // Prefixes only accumulate; any non-prefix byte closes the event.
  always_comb begin
    next_state   = state;
    push         = 1'b0;
    bat          = 1'b0;
    new_evt.ext  = (state == DEC_E0) || (state == DEC_E0F0);
    new_evt.rel  = (state == DEC_F0) || (state == DEC_E0F0);
    new_evt.code = rx_byte;
    if (frame_err || parity_err) begin
      next_state = DEC_IDLE;
    end else if (byte_valid) begin
      if (rx_byte == SCAN_E0) begin
        next_state = (state == DEC_F0 || state == DEC_E0F0) ? DEC_E0F0 : DEC_E0;
      end else if (rx_byte == SCAN_F0) begin
        next_state = (state == DEC_E0 || state == DEC_E0F0) ? DEC_E0F0 : DEC_F0;
      end else if (rx_byte == SCAN_BAT && state == DEC_IDLE) begin
        bat = 1'b1;
      end else begin
        push       = 1'b1;
        next_state = DEC_IDLE;
      end
    end
  end

  assign pop = evt_valid && evt_ready;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (new_evt),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign evt_valid    = !fifo_empty;
  assign evt_code     = head.code;
  assign evt_release  = head.rel;
  assign evt_extended = head.ext;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for the PS/2 key controller: a vector table of single frames
// plus hand-written sequences for latency, timeout and FIFO-full behaviour.
module tb_ps2_key_controller;

  localparam int TIMEOUT = 300;
  localparam int DEPTH   = 8;
  localparam int HALF    = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_release;
  logic       evt_extended;
  logic [3:0] fifo_count;
  logic       reset_seen;
  logic       frame_err;
  logic       parity_err;
  logic       overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fe_cnt    = 0;
  int pe_cnt    = 0;
  int bat_cnt   = 0;
  int ovf_cnt   = 0;

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       bad_stop;
    logic       exp_evt;
    logic [7:0] exp_code;
    logic       exp_rel;
    logic       exp_ext;
    int         exp_fe;
    int         exp_pe;
    int         exp_bat;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  ps2_key_controller #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_release  (evt_release),
    .evt_extended (evt_extended),
    .fifo_count   (fifo_count),
    .reset_seen   (reset_seen),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overflow     (overflow)
  );

  // Pulse counters; a pulse stuck high shows up as an inflated count.
  always @(negedge clk) begin
    if (rst) begin
      fe_cnt  += int'(frame_err);
      pe_cnt  += int'(parity_err);
      bat_cnt += int'(reset_seen);
      ovf_cnt += int'(overflow);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
  endtask

  function automatic logic [10:0] make_word(input logic [7:0] d, input logic flip,
                                            input logic bad_stop);
    logic p;
    p = (~^d) ^ flip;
    return {~bad_stop, p, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic flip, input logic bad_stop);
    logic [10:0] w;
    w = make_word(d, flip, bad_stop);
    for (int i = 0; i < 11; i++) ps2_bit(w[i]);
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  // Sends ten bits, then drops ps2_clk for the stop bit and returns at once.
  task automatic send_up_to_last_fall(input logic [7:0] d);
    logic [10:0] w;
    w = make_word(d, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) ps2_bit(w[i]);
    ps2_data = w[10];
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
  endtask

  task automatic finish_last_bit();
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic pop_event(input string name, input logic [7:0] code,
                           input logic rel, input logic ext);
    @(negedge clk);
    for (int i = 0; i < 200 && !evt_valid; i++) @(negedge clk);
    checkOutput({name, "_valid"}, int'(evt_valid), 1);
    checkOutput({name, "_code"}, int'(evt_code), int'(code));
    checkOutput({name, "_rel"}, int'(evt_release), int'(rel));
    checkOutput({name, "_ext"}, int'(evt_extended), int'(ext));
    if (evt_valid) begin
      evt_ready = 1'b1;
      @(posedge clk);
      #1 evt_ready = 1'b0;
    end
  endtask

  initial begin
    int fe0, pe0, bat0, ovf0;

    vecs[0]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[1]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 0, 0, 0};
    vecs[2]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[3]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[4]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 0, 0, 0};
    vecs[5]  = '{8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 1};
    vecs[6]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[7]  = '{8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 0, 0, 0};
    vecs[8]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1, 0};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[10] = '{8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 0};
    vecs[11] = '{8'h74, 1'b0, 1'b0, 1'b1, 8'h74, 1'b0, 1'b0, 0, 0, 0};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[13] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[14] = '{8'h70, 1'b0, 1'b0, 1'b1, 8'h70, 1'b0, 1'b1, 0, 0, 0};

    rst       = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    evt_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_evt_valid", int'(evt_valid), 0);
    checkOutput("rst_fifo_count", int'(fifo_count), 0);
    checkOutput("rst_evt_code", int'(evt_code), 0);
    checkOutput("rst_frame_err", int'(frame_err), 0);
    checkOutput("rst_parity_err", int'(parity_err), 0);
    checkOutput("rst_reset_seen", int'(reset_seen), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Single make code with exact push latency.
    $display("[TB] sequence: 0x1C latency");
    send_up_to_last_fall(8'h1C);
    repeat (3) @(posedge clk);
    #1 checkOutput("t1_valid_before_n2", int'(evt_valid), 0);
    @(posedge clk);
    #1 checkOutput("t1_valid_at_n2", int'(evt_valid), 1);
    checkOutput("t1_code", int'(evt_code), 'h1C);
    checkOutput("t1_rel", int'(evt_release), 0);
    checkOutput("t1_ext", int'(evt_extended), 0);
    checkOutput("t1_count", int'(fifo_count), 1);
    finish_last_bit();
    evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    checkOutput("t1_count_after_pop", int'(fifo_count), 0);

    $display("[TB] vector table");
    for (int i = 0; i < 15; i++) begin
      fe0  = fe_cnt;
      pe0  = pe_cnt;
      bat0 = bat_cnt;
      applyStimulus(vecs[i].data, vecs[i].flip, vecs[i].bad_stop);
      checkOutput($sformatf("v%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
      checkOutput($sformatf("v%0d_parity_err", i), pe_cnt - pe0, vecs[i].exp_pe);
      checkOutput($sformatf("v%0d_reset_seen", i), bat_cnt - bat0, vecs[i].exp_bat);
      checkOutput($sformatf("v%0d_count", i), int'(fifo_count), int'(vecs[i].exp_evt));
      if (vecs[i].exp_evt)
        pop_event($sformatf("v%0d", i), vecs[i].exp_code, vecs[i].exp_rel, vecs[i].exp_ext);
    end

    // Partial frame abandoned by the keyboard.
    $display("[TB] sequence: timeout");
    fe0 = fe_cnt;
    begin
      logic [10:0] w;
      w = make_word(8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(w[i]);
    end
    ps2_data = 1'b1;
    repeat (TIMEOUT - 50) @(posedge clk);
    checkOutput("t5_no_early_timeout", fe_cnt - fe0, 0);
    for (int i = 0; i < 200 && fe_cnt == fe0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    checkOutput("t5_timeout_frame_err", fe_cnt - fe0, 1);
    checkOutput("t5_count", int'(fifo_count), 0);
    applyStimulus(8'h29, 1'b0, 1'b0);
    checkOutput("t5_no_extra_err", fe_cnt - fe0, 1);
    pop_event("t5_after", 8'h29, 1'b0, 1'b0);

    // Fill the FIFO, overflow once, then push and pop together while full.
    $display("[TB] sequence: fifo full");
    ovf0 = ovf_cnt;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'(8'h10 + i), 1'b0, 1'b0);
    checkOutput("t6_count_full", int'(fifo_count), DEPTH);
    checkOutput("t6_overflow_once", ovf_cnt - ovf0, 1);
    checkOutput("t6_head_code", int'(evt_code), 'h10);
    send_up_to_last_fall(8'h20);
    repeat (3) @(posedge clk);
    #1 evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    finish_last_bit();
    checkOutput("t6_no_overflow_with_pop", ovf_cnt - ovf0, 1);
    checkOutput("t6_count_still_full", int'(fifo_count), DEPTH);
    for (int i = 1; i < DEPTH; i++)
      pop_event($sformatf("t6_drain%0d", i), 8'(8'h10 + i), 1'b0, 1'b0);
    pop_event("t6_drain_last", 8'h20, 1'b0, 1'b0);
    #1 checkOutput("t6_count_empty", int'(fifo_count), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
